control_sequencer: RTL and testbench

- Hardwired Moore-style control unit that sequences the 32-bit CPU datapath.
- Runs the fetch (T0–T2), decode and execute (T3–T7) steps for every instruction.
- Drives every register-enable, bus-select, register-decoder, ALU-op and memory strobe the datapath consumes.
- Sits between the datapath, the memory and the external run/stop interface.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/ctrl_class_decode.sv | 43 ++++
 rtl/control_sequencer.sv | 162 ++++++++++++++++
 tb/tb_control_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, sequencer states and instruction classes for the
// hardwired CPU control unit.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } class_t;

endpackage

// File: rtl/ctrl_class_decode.sv
// Opcode -> instruction class, final execute step, ALU operation and legality.
import cpu_ctrl_pkg::*;

module ctrl_class_decode (
    input  logic [4:0] op,
    output class_t     cls,
    output state_t     last_step,
    output logic [4:0] alu_op,
    output logic       legal
);

    always_comb begin
        cls       = CL_NOP;
        last_step = T3;
        alu_op    = op;
        legal     = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
                cls = CL_RTYPE; last_step = T5;
            end
            OP_ADDI: begin cls = CL_IMM; last_step = T5; alu_op = OP_ADD; end
            OP_ANDI: begin cls = CL_IMM; last_step = T5; alu_op = OP_AND; end
            OP_ORI:  begin cls = CL_IMM; last_step = T5; alu_op = OP_OR;  end
            OP_NEG, OP_NOT: begin cls = CL_UNARY; last_step = T4; end
            OP_MUL, OP_DIV: begin cls = CL_MULDIV; last_step = T6; end
            // Memory ops and branches compute their effective address with ADD.
            OP_LD:   begin cls = CL_LD;  last_step = T7; alu_op = OP_ADD; end
            OP_LDI:  begin cls = CL_LDI; last_step = T5; alu_op = OP_ADD; end
            OP_ST:   begin cls = CL_ST;  last_step = T7; alu_op = OP_ADD; end
            OP_BR:   begin cls = CL_BR;  last_step = T6; alu_op = OP_ADD; end
            OP_JR:   cls = CL_JR;
            OP_JAL:  begin cls = CL_JAL; last_step = T4; end
            OP_IN:   cls = CL_IN;
            OP_OUT:  cls = CL_OUT;
            OP_MFHI: cls = CL_MFHI;
            OP_MFLO: cls = CL_MFLO;
            OP_NOP:  cls = CL_NOP;
            OP_HALT: cls = CL_HALT;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T7, HALT.
// Strobes are decoded from the state register and the latched IR.
import cpu_ctrl_pkg::*;

module control_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        con_ff_bit,
    input  logic        stop,
    output logic        IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in,
    output logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, CONin,
    output logic [4:0]  opcode,
    output logic        IncPC,
    output logic        Mem_read,
    output logic        Mem_write,
    output logic        run,
    output logic        illegal_op
);

    state_t     state, state_nx;
    logic [2:0] wait_cnt, wait_nx;
    logic       ill_q, ill_nx;
    logic       wait_state, wait_last;

    class_t     cls;
    state_t     last_step;
    logic [4:0] alu_op;
    logic       legal;

    logic       unused_ir;
    assign unused_ir = ^IR[26:0];

    ctrl_class_decode u_dec (
        .op        (IR[31:27]),
        .cls       (cls),
        .last_step (last_step),
        .alu_op    (alu_op),
        .legal     (legal)
    );

    // Memory-facing steps repeat until the wait counter reaches MEM_WAIT.
    assign wait_last  = (wait_cnt == 3'(MEM_WAIT));
    assign wait_state = (state == T1) ||
                        (state == T6 && cls == CL_LD) ||
                        (state == T7 && cls == CL_ST);

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= T0;
            wait_cnt <= '0;
            ill_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            ill_q    <= ill_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = '0;
        ill_nx   = ill_q;
        if (state == T3 && !legal)
            ill_nx = 1'b1;
        if (wait_state && !wait_last) begin
            wait_nx = wait_cnt + 3'd1;
        end else begin
            case (state)
                T0:   state_nx = T1;
                T1:   state_nx = T2;
                T2:   state_nx = T3;
                HALT: state_nx = HALT;
                default: begin
                    if (state == T3 && cls == CL_HALT)
                        state_nx = HALT;
                    else if (state == last_step)
                        state_nx = stop ? HALT : T0;
                    else
                        state_nx = state_t'(state + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in,
         HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
         Gra, Grb, Grc, Rin, Rout, BAout, CONin, IncPC, Mem_read, Mem_write} = '0;
        opcode     = IR[31:27];
        run        = (state != HALT);
        illegal_op = ill_q;
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1; end
            T1: begin
                Zlo_out = 1'b1; Mem_read = 1'b1;
                if (wait_last) begin PCin = 1'b1; MDRin = 1'b1; end
            end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: case (cls)
                CL_RTYPE, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; RYin = 1'b1; end
                CL_UNARY:  begin Grb = 1'b1; Rout = 1'b1; RZin = 1'b1; opcode = alu_op; end
                CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; RYin = 1'b1; end
                CL_LD, CL_LDI, CL_ST: begin
                    Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; RYin = 1'b1;
                end
                CL_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                CL_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                CL_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                CL_IN:   begin Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CL_OUT:  begin Gra = 1'b1; Rout = 1'b1; Outport_in = 1'b1; end
                CL_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CL_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
            T4: case (cls)
                CL_RTYPE:  begin Grc = 1'b1; Rout = 1'b1; RZin = 1'b1; opcode = alu_op; end
                CL_IMM, CL_LD, CL_LDI, CL_ST: begin
                    Cout = 1'b1; RZin = 1'b1; opcode = alu_op;
                end
                CL_UNARY:  begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CL_MULDIV: begin Grb = 1'b1; Rout = 1'b1; RZin = 1'b1; opcode = alu_op; end
                CL_BR:     begin PCout = 1'b1; RYin = 1'b1; end
                CL_JAL:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                default: ;
            endcase
            T5: case (cls)
                CL_RTYPE, CL_IMM, CL_LDI: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CL_MULDIV:   begin Zlo_out = 1'b1; LOin = 1'b1; end
                CL_LD, CL_ST: begin Zlo_out = 1'b1; MARin = 1'b1; end
                CL_BR:       begin Cout = 1'b1; RZin = 1'b1; opcode = alu_op; end
                default: ;
            endcase
            T6: case (cls)
                CL_MULDIV: begin Zhi_out = 1'b1; HIin = 1'b1; end
                CL_LD:     begin Mem_read = 1'b1; MDRin = wait_last; end
                CL_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                CL_BR:     if (con_ff_bit) begin Zlo_out = 1'b1; PCin = 1'b1; end
                default: ;
            endcase
            T7: case (cls)
                CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CL_ST:   Mem_write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
        // Nothing leaves the unit while clear is being sampled.
        if (clear) begin
            {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in,
             HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
             Gra, Grb, Grc, Rin, Rout, BAout, CONin, IncPC, Mem_read, Mem_write} = '0;
            opcode     = '0;
            run        = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: a per-instruction step table predicts every cycle's
// strobes; a negedge monitor compares them against the sequencer.
module tb_control_sequencer;

    localparam int W = 2;

    localparam bit [4:0] LD = 0, LDI = 1, ST = 2, ADD = 3, SUB = 4, SHR = 5, SHRA = 6,
        SHL = 7, ROR = 8, ROL = 9, AND = 10, OR = 11, ADDI = 12, ANDI = 13, ORI = 14,
        MUL = 15, DIV = 16, NEG = 17, NOT = 18, BR = 19, JR = 20, JAL = 21, IN = 22,
        OUT = 23, MFHI = 24, MFLO = 25, NOP = 26, HLT = 27;

    localparam logic [28:0] M_IRIN = 29'h1 << 28, M_PCIN = 29'h1 << 27, M_RYIN = 29'h1 << 26,
        M_RZIN = 29'h1 << 25, M_MARIN = 29'h1 << 24, M_MDRIN = 29'h1 << 23,
        M_HIIN = 29'h1 << 22, M_LOIN = 29'h1 << 21, M_OUTP = 29'h1 << 20,
        M_HIOUT = 29'h1 << 19, M_LOOUT = 29'h1 << 18, M_ZHI = 29'h1 << 17,
        M_ZLO = 29'h1 << 16, M_PCOUT = 29'h1 << 15, M_MDROUT = 29'h1 << 14,
        M_INP = 29'h1 << 13, M_COUT = 29'h1 << 12, M_GRA = 29'h1 << 11,
        M_GRB = 29'h1 << 10, M_GRC = 29'h1 << 9, M_RIN = 29'h1 << 8, M_ROUT = 29'h1 << 7,
        M_BA = 29'h1 << 6, M_CON = 29'h1 << 5, M_INC = 29'h1 << 4, M_MRD = 29'h1 << 3,
        M_MWR = 29'h1 << 2, M_RUN = 29'h1 << 1, M_ILL = 29'h1;

    typedef struct packed { logic [28:0] s; logic [4:0] op; } exp_t;

    logic        clock = 1'b0;
    logic        clear, con_ff_bit, stop;
    logic [31:0] IR;
    logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CONin;
    logic [4:0] opcode;
    logic IncPC, Mem_read, Mem_write, run, illegal_op;

    always #5 clock = ~clock;

    control_sequencer #(.MEM_WAIT(W)) dut (
        .clock(clock), .clear(clear), .IR(IR), .con_ff_bit(con_ff_bit), .stop(stop),
        .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
        .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in), .HIout(HIout), .LOout(LOout),
        .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout), .MDRout(MDRout),
        .Inport_out(Inport_out), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .CONin(CONin), .opcode(opcode), .IncPC(IncPC),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .run(run), .illegal_op(illegal_op)
    );

    wire [28:0] act_s = {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in,
        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
        Gra, Grb, Grc, Rin, Rout, BAout, CONin, IncPC, Mem_read, Mem_write, run, illegal_op};

    exp_t exp_q[$];
    exp_t seq[$];
    exp_t mon_e;
    int   errors = 0, checks = 0;
    bit   mdl_ill = 0;

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act_s !== mon_e.s || opcode !== mon_e.op) begin
                errors++;
                $display("FAIL strobes t=%0t: got s=%h op=%h, expected s=%h op=%h",
                         $time, act_s, opcode, mon_e.s, mon_e.op);
            end
        end
    end

    task automatic put(input logic [28:0] bits, input logic [4:0] o);
        seq.push_back({bits | M_RUN | (mdl_ill ? M_ILL : 29'd0), o});
    endtask

    // Reference: the step table for one instruction, fetch included.
    task automatic gen(input logic [31:0] ir, input logic con, input logic stp, output bit halts);
        logic [4:0] op;
        op = ir[31:27];
        seq.delete();
        halts = stp;
        put(M_PCOUT | M_MARIN | M_INC | M_RZIN, op);
        for (int i = 0; i <= W; i++)
            put(M_ZLO | M_MRD | ((i == W) ? (M_PCIN | M_MDRIN) : 29'd0), op);
        put(M_MDROUT | M_IRIN, op);
        case (op)
            ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL: begin
                put(M_GRB | M_ROUT | M_RYIN, op);
                put(M_GRC | M_ROUT | M_RZIN, op);
                put(M_ZLO | M_GRA | M_RIN, op);
            end
            ADDI, ANDI, ORI: begin
                put(M_GRB | M_ROUT | M_RYIN, op);
                put(M_COUT | M_RZIN, (op == ADDI) ? ADD : (op == ANDI) ? AND : OR);
                put(M_ZLO | M_GRA | M_RIN, op);
            end
            NEG, NOT: begin
                put(M_GRB | M_ROUT | M_RZIN, op);
                put(M_ZLO | M_GRA | M_RIN, op);
            end
            MUL, DIV: begin
                put(M_GRA | M_ROUT | M_RYIN, op);
                put(M_GRB | M_ROUT | M_RZIN, op);
                put(M_ZLO | M_LOIN, op);
                put(M_ZHI | M_HIIN, op);
            end
            LD, LDI, ST: begin
                put(M_GRB | M_ROUT | M_BA | M_RYIN, op);
                put(M_COUT | M_RZIN, ADD);
                if (op == LDI) put(M_ZLO | M_GRA | M_RIN, op);
                else put(M_ZLO | M_MARIN, op);
                if (op == LD) begin
                    for (int i = 0; i <= W; i++) put(M_MRD | ((i == W) ? M_MDRIN : 29'd0), op);
                    put(M_MDROUT | M_GRA | M_RIN, op);
                end
                if (op == ST) begin
                    put(M_GRA | M_ROUT | M_MDRIN, op);
                    for (int i = 0; i <= W; i++) put(M_MWR, op);
                end
            end
            BR: begin
                put(M_GRA | M_ROUT | M_CON, op);
                put(M_PCOUT | M_RYIN, op);
                put(M_COUT | M_RZIN, ADD);
                put(con ? (M_ZLO | M_PCIN) : 29'd0, op);
            end
            JR:   put(M_GRA | M_ROUT | M_PCIN, op);
            JAL: begin
                put(M_PCOUT | M_GRB | M_RIN, op);
                put(M_GRA | M_ROUT | M_PCIN, op);
            end
            IN:   put(M_INP | M_GRA | M_RIN, op);
            OUT:  put(M_GRA | M_ROUT | M_OUTP, op);
            MFHI: put(M_HIOUT | M_GRA | M_RIN, op);
            MFLO: put(M_LOOUT | M_GRA | M_RIN, op);
            NOP:  put(29'd0, op);
            HLT: begin put(29'd0, op); halts = 1; end
            default: begin put(29'd0, op); mdl_ill = 1; end
        endcase
    endtask

    task automatic do_clear();
        clear = 1'b1;
        exp_q.push_back('0);
        mdl_ill = 0;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    // Runs one instruction from T0; clr_at >= 0 asserts clear on that step.
    task automatic issue(input logic [31:0] ir, input logic con, input logic stp,
                         input int clr_at = -1);
        bit halts;
        int n;
        IR = ir; con_ff_bit = con; stop = stp;
        gen(ir, con, stp, halts);
        n = (clr_at >= 0) ? clr_at : seq.size();
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
        repeat (n) @(posedge clock);
        #1;
        if (clr_at >= 0) begin
            do_clear();
        end else if (halts) begin
            for (int i = 0; i < 3; i++) exp_q.push_back({(mdl_ill ? M_ILL : 29'd0), ir[31:27]});
            repeat (3) @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [31:0] mk(input bit [4:0] op, input int ra, input int rb,
                                       input int rc, input int imm);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'(imm)};
    endfunction

    initial begin
        logic [4:0] rop;
        int r;
        clear = 1'b1; IR = '0; con_ff_bit = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        do_clear();

        issue(mk(ADD, 1, 2, 3, 0), 1'b0, 1'b0);
        issue(mk(LD, 4, 0, 0, 'h10), 1'b0, 1'b0);
        issue(mk(ST, 5, 1, 0, 'h20), 1'b0, 1'b0);
        issue(mk(BR, 2, 0, 0, 4), 1'b0, 1'b0);
        issue(mk(BR, 2, 0, 0, 4), 1'b1, 1'b0);
        issue(mk(ADDI, 6, 7, 0, 9), 1'b0, 1'b0);
        issue(mk(JAL, 3, 3, 0, 0), 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 28);
            rop = (r == 28) ? 5'b11101 : (r == 27) ? NOP : 5'(r);
            issue({rop, 27'($urandom)}, 1'($urandom), 1'b0);
        end
        do_clear();

        issue(mk(MUL, 2, 3, 0, 0), 1'b0, 1'b1);
        do_clear();
        issue(mk(HLT, 0, 0, 0, 0), 1'b0, 1'b0);
        do_clear();
        issue({5'b11111, 27'd0}, 1'b0, 1'b0);
        issue(mk(NOP, 0, 0, 0, 0), 1'b0, 1'b0);
        issue(mk(ADD, 1, 2, 3, 0), 1'b0, 1'b0, W + 4);
        issue(mk(NOP, 0, 0, 0, 0), 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected steps never observed, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
